bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NREQ, 4, number of requesters; index 0 = core0 dcache, 1 = core0 icache, 2 = core1 dcache, 3 = core1 icache.
REQ-002 The block SHALL have this parameter: AW, 32, address and data width.
REQ-003 Ports (name, direction, width, meaning):
- CLK, input, 1, clock.
- nRST, input, 1, reset, asynchronous, active-low.
REQ-004 req_ren, input, NREQ, per-requester read request.
REQ-005 req_wen, input, NREQ, per-requester write request.
REQ-006 req_addr, input, NREQ x AW, per-requester word address.
REQ-007 req_store, input, NREQ x AW, per-requester write data.
REQ-008 req_wait, output, NREQ, per-requester stall; low means the access completed this cycle.
REQ-009 req_load, output, AW, read data shared by all requesters; valid only for the requester whose req_wait is low.
REQ-010 ramREN, output, 1, RAM read enable.
REQ-011 ramWEN, output, 1, RAM write enable.
REQ-012 ramaddr, output, AW, RAM address.
REQ-013 ramstore, output, AW, RAM write data.
REQ-014 ramload, input, AW, RAM read data.
REQ-015 ramstate, input, 2, RAM status; 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-016 grant, output, 2, index of the current or last granted requester.
REQ-017 busy, output, 1, high while the FSM is in GRANT.

Function
REQ-018 A requester is active when req_ren[i] OR req_wen[i] is high.
REQ-019 The FSM SHALL have two states, IDLE and GRANT.
REQ-020 In IDLE with any active requester, the arbiter SHALL latch the winner into grant and move to GRANT at the next edge.
- Grant-to-RAM latency is 1 cycle.
REQ-021 Winner selection SHALL be round-robin: the first active index found searching upward from the 2-bit pointer rr_ptr, wrapping 3 -> 0.
REQ-022 On each completion, rr_ptr SHALL become (grant + 1) mod 4.
- 2-bit wrap: grant 3 gives pointer 0.
REQ-023 In IDLE, ramREN and ramWEN SHALL be 0.
REQ-024 In IDLE, every req_wait bit SHALL be 1 for active requesters and 0 for inactive ones.
REQ-025 In GRANT, ramaddr and ramstore SHALL be combinationally driven from req_addr[grant] and req_store[grant].
REQ-026 In GRANT, if req_wen[grant] is high: ramWEN = 1 and ramREN = 0.
- Write wins when both req_wen and req_ren are high.
REQ-027 In GRANT, if only req_ren[grant] is high: ramREN = 1 and ramWEN = 0.
REQ-028 req_load SHALL equal ramload combinationally at all times.
REQ-029 In GRANT with ramstate == ACCESS:
- req_wait[grant] SHALL be 0 in that same cycle.
- The FSM SHALL return to IDLE at the next edge, updating rr_ptr.
REQ-030 In GRANT with ramstate FREE, BUSY or ERROR:
- req_wait[grant] SHALL stay 1.
- The FSM SHALL remain in GRANT and keep driving the RAM request (ERROR is retried).
REQ-031 In GRANT, all non-granted active requesters SHALL see req_wait = 1.
REQ-032 If the granted requester deasserts both enables while in GRANT:
- ram enables SHALL drop in that same cycle.
- The FSM SHALL return to IDLE at the next edge with rr_ptr unchanged and no completion signalled.
REQ-033 A completion and a new request in the same cycle SHALL NOT grant in that cycle.
- The new request is arbitrated in IDLE on the following cycle, so at least one IDLE cycle separates grants.
REQ-034 Requesters SHALL hold their address, data and enables stable until req_wait goes low; the arbiter does not latch them.

Reset
REQ-035 On nRST low, asynchronously: FSM = IDLE, grant = 0, rr_ptr = 0, busy = 0.
REQ-036 Assertion of nRST mid-GRANT SHALL abort the access immediately: ram enables go to 0 and no completion is signalled.
REQ-037 After reset release, the first arbitration SHALL start from index 0.

Verification
REQ-038 Single read: req_ren[1] = 1, addr 0x40, RAM returns ACCESS after 3 cycles with ramload 0xDEADBEEF.
- Required: grant = 1 and ramREN = 1 one cycle after the request.
- Required: req_wait[1] = 0 with req_load = 0xDEADBEEF in the ACCESS cycle.
- Required: IDLE on the next cycle.
REQ-039 All four requesters active continuously, RAM ACCESS on each first GRANT cycle.
- Required: grant sequence 0, 1, 2, 3, 0, each grant separated by one IDLE cycle.
REQ-040 req_ren[2] = 1 and req_wen[2] = 1, addr 0x80, store 0x12345678.
- Required: ramWEN = 1, ramREN = 0, ramaddr = 0x80, ramstore = 0x12345678.
REQ-041 ramstate = ERROR for 2 cycles, then ACCESS.
- Required: req_wait stays 1 during ERROR and the RAM request is held.
- Required: completion occurs on the ACCESS cycle.
REQ-042 Requester 3 granted, then it drops req_ren while ramstate = BUSY.
- Required: ram enables 0 in that cycle, FSM in IDLE next cycle, rr_ptr still 3.
REQ-043 nRST pulsed low during GRANT of requester 2.
- Required: ramREN = ramWEN = 0 and busy = 0 immediately.
- Required: the next arbitration with all four requesters active grants index 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that multiplexes NREQ cache ports onto one RAM port.
// Handles one access at a time; completion is signalled by RAM ACCESS.
module bus_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*AW-1:0]   req_store,
  output logic [NREQ-1:0]      req_wait,
  output logic [AW-1:0]        req_load,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [AW-1:0]        ramstore,
  input  logic [AW-1:0]        ramload,
  input  logic [1:0]           ramstate,
  output logic [1:0]           grant,
  output logic                 busy
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] active;
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [AW-1:0]   store_arr [NREQ];
  logic [1:0]      winner;
  logic            any_active;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign active[gi]    = req_ren[gi] | req_wen[gi];
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign store_arr[gi] = req_store[gi*AW +: AW];
    end
  endgenerate

  assign any_active = |active;

  // First active index at or above rr_ptr, wrapping through the 2-bit space.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = rr_ptr_q + 2'(off);
      if (!found && active[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_active) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request aborts without advancing the pointer.
        if (!active[grant_q]) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    req_wait = active;
    if (state_q == GRANT) begin
      if (req_wen[grant_q]) begin
        ramWEN = 1'b1;
      end else if (req_ren[grant_q]) begin
        ramREN = 1'b1;
      end
      if (ramstate == RAM_ACCESS) begin
        req_wait[grant_q] = 1'b0;
      end
    end
  end

  assign ramaddr  = addr_arr[grant_q];
  assign ramstore = store_arr[grant_q];
  assign req_load = ramload;
  assign grant    = grant_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table plus a
// hand-written mid-grant reset sequence.
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;

  logic                CLK;
  logic                nRST;
  logic [NREQ-1:0]     req_ren;
  logic [NREQ-1:0]     req_wen;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*AW-1:0]  req_store;
  logic [NREQ-1:0]     req_wait;
  logic [AW-1:0]       req_load;
  logic                ramREN;
  logic                ramWEN;
  logic [AW-1:0]       ramaddr;
  logic [AW-1:0]       ramstore;
  logic [AW-1:0]       ramload;
  logic [1:0]          ramstate;
  logic [1:0]          grant;
  logic                busy;

  bus_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant(grant), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [1:0] FREE = 2'd0, BSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic [AW-1:0] addr_tbl  [NREQ];
  logic [AW-1:0] store_tbl [NREQ];

  typedef struct {
    logic [3:0] ren;
    logic [3:0] wen;
    logic [1:0] rs;
    logic [3:0] e_wait;
    logic       e_ren;
    logic       e_wen;
    logic [1:0] e_grant;
    logic       e_busy;
  } vec_t;

  vec_t vecs [30];
  int   nvec;
  int   total;
  int   bad;

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%08h want=0x%08h", name, step, act, exp_v);
    end
  endtask

  task automatic add(input logic [3:0] ren, input logic [3:0] wen, input logic [1:0] rs,
                     input logic [3:0] ew, input logic er, input logic ewn,
                     input logic [1:0] eg, input logic eb);
    vecs[nvec].ren = ren;   vecs[nvec].wen = wen;  vecs[nvec].rs = rs;
    vecs[nvec].e_wait = ew; vecs[nvec].e_ren = er; vecs[nvec].e_wen = ewn;
    vecs[nvec].e_grant = eg; vecs[nvec].e_busy = eb;
    nvec++;
  endtask

  initial begin
    total = 0; bad = 0; nvec = 0;
    addr_tbl[0] = 32'h10;  store_tbl[0] = 32'h11111111;
    addr_tbl[1] = 32'h40;  store_tbl[1] = 32'h22222222;
    addr_tbl[2] = 32'h80;  store_tbl[2] = 32'h12345678;
    addr_tbl[3] = 32'hC0;  store_tbl[3] = 32'h44444444;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = addr_tbl[i];
      req_store[i*AW +: AW] = store_tbl[i];
    end

    //   ren      wen      rs    wait    REN   WEN   grant busy
    add(4'b0000, 4'b0000, FREE, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // all four active: grants 0,1,2,3,0 with an IDLE cycle between each
    add(4'b1111, 4'b0000, ACC,  4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    add(4'b1111, 4'b0000, ACC,  4'b1110, 1'b1, 1'b0, 2'd0, 1'b1);
    add(4'b1111, 4'b0000, ACC,  4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    add(4'b1111, 4'b0000, ACC,  4'b1101, 1'b1, 1'b0, 2'd1, 1'b1);
    add(4'b1111, 4'b0000, ACC,  4'b1111, 1'b0, 1'b0, 2'd1, 1'b0);
    add(4'b1111, 4'b0000, ACC,  4'b1011, 1'b1, 1'b0, 2'd2, 1'b1);
    add(4'b1111, 4'b0000, ACC,  4'b1111, 1'b0, 1'b0, 2'd2, 1'b0);
    add(4'b1111, 4'b0000, ACC,  4'b0111, 1'b1, 1'b0, 2'd3, 1'b1);
    add(4'b1111, 4'b0000, ACC,  4'b1111, 1'b0, 1'b0, 2'd3, 1'b0);
    add(4'b1111, 4'b0000, ACC,  4'b1110, 1'b1, 1'b0, 2'd0, 1'b1);
    // single read by requester 1, RAM busy for 3 cycles
    add(4'b0010, 4'b0000, FREE, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    add(4'b0010, 4'b0000, BSY,  4'b0010, 1'b1, 1'b0, 2'd1, 1'b1);
    add(4'b0010, 4'b0000, BSY,  4'b0010, 1'b1, 1'b0, 2'd1, 1'b1);
    add(4'b0010, 4'b0000, BSY,  4'b0010, 1'b1, 1'b0, 2'd1, 1'b1);
    add(4'b0010, 4'b0000, ACC,  4'b0000, 1'b1, 1'b0, 2'd1, 1'b1);
    add(4'b0000, 4'b0000, FREE, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
    // requester 2 read+write: write wins; ERROR twice is retried
    add(4'b0100, 4'b0100, FREE, 4'b0100, 1'b0, 1'b0, 2'd1, 1'b0);
    add(4'b0100, 4'b0100, BSY,  4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
    add(4'b0100, 4'b0100, ERR,  4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
    add(4'b0100, 4'b0100, ERR,  4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
    add(4'b0100, 4'b0100, ACC,  4'b0000, 1'b0, 1'b1, 2'd2, 1'b1);
    add(4'b0000, 4'b0000, FREE, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    // requester 3 withdraws while BUSY; pointer must remain at 3
    add(4'b1000, 4'b0000, FREE, 4'b1000, 1'b0, 1'b0, 2'd2, 1'b0);
    add(4'b1000, 4'b0000, BSY,  4'b1000, 1'b1, 1'b0, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, BSY,  4'b0000, 1'b0, 1'b0, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, FREE, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
    add(4'b1111, 4'b0000, FREE, 4'b1111, 1'b0, 1'b0, 2'd3, 1'b0);
    add(4'b1111, 4'b0000, ACC,  4'b0111, 1'b1, 1'b0, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, FREE, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);

    nRST = 1'b0; req_ren = '0; req_wen = '0; ramstate = FREE; ramload = 32'hDEADBEEF;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy",  -1, 32'(busy),   32'd0);
    check("rst_grant", -1, 32'(grant),  32'd0);
    check("rst_ren",   -1, 32'(ramREN), 32'd0);
    check("rst_wen",   -1, 32'(ramWEN), 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int s = 0; s < nvec; s++) begin
      req_ren  = vecs[s].ren;
      req_wen  = vecs[s].wen;
      ramstate = vecs[s].rs;
      ramload  = 32'hDEADBEEF ^ 32'(s);
      #3;
      check("req_wait", s, 32'(req_wait), 32'(vecs[s].e_wait));
      check("ramREN",   s, 32'(ramREN),   32'(vecs[s].e_ren));
      check("ramWEN",   s, 32'(ramWEN),   32'(vecs[s].e_wen));
      check("grant",    s, 32'(grant),    32'(vecs[s].e_grant));
      check("busy",     s, 32'(busy),     32'(vecs[s].e_busy));
      check("req_load", s, req_load,      32'hDEADBEEF ^ 32'(s));
      if (vecs[s].e_busy) begin
        check("ramaddr",  s, ramaddr,  addr_tbl[vecs[s].e_grant]);
        check("ramstore", s, ramstore, store_tbl[vecs[s].e_grant]);
      end
      $display("step %0d ren=%b wen=%b rs=%0d -> wait=%b REN=%b WEN=%b grant=%0d busy=%b",
               s, req_ren, req_wen, ramstate, req_wait, ramREN, ramWEN, grant, busy);
      @(posedge CLK); #1;
    end

    // reset during GRANT of requester 2 aborts the access at once
    req_ren = 4'b0100; req_wen = 4'b0000; ramstate = BSY;
    @(posedge CLK); #1;
    check("pre_rst_grant", 100, 32'(grant),  32'd2);
    check("pre_rst_ren",   100, 32'(ramREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("mid_rst_ren",   101, 32'(ramREN), 32'd0);
    check("mid_rst_wen",   101, 32'(ramWEN), 32'd0);
    check("mid_rst_busy",  101, 32'(busy),   32'd0);
    check("mid_rst_grant", 101, 32'(grant),  32'd0);
    $display("reset pulse: REN=%b WEN=%b busy=%b grant=%0d", ramREN, ramWEN, busy, grant);
    req_ren = 4'b1111; ramstate = ACC;
    #3;
    nRST = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_grant", 102, 32'(grant), 32'd0);
    check("post_rst_busy",  102, 32'(busy),  32'd1);
    check("post_rst_wait",  102, 32'(req_wait), 32'(4'b1110));
    $display("after reset: grant=%0d busy=%b wait=%b", grant, busy, req_wait);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
